// File: rtl/rtc_seg_scan.sv
// Purpose: scans six RTC BCD digits onto a time-multiplexed 7-segment display,
//          with a per-frame tear-free snapshot, guard blanking, colon dots,
//          leading-zero blanking, per-digit blink and a sticky invalid-time flag.
// Latency: an/seg/dp are registered, one clk after the slot state that selects them;
//          inputs are sampled only at the frame boundary (last cycle of slot 5).
// Backpressure: none; free-running scan, inputs are sampled and never stalled.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high, overrides everything
//   hrm..secl   BCD time digits from the RTC counter (hours/min/sec, tens/units)
//   blink_en    global blink enable
//   blink_mask  per-slot blink select, bit i = slot i
//   an          one-hot digit enable, active-high (slot 0 = seconds units)
//   seg         segments {g,f,e,d,c,b,a}, active-high
//   dp          colon / decimal point, active-high
//   err         sticky flag: a captured snapshot was not a legal 24h time
module rtc_seg_scan #(
  parameter int SCAN_DIV      = 500,  // clk cycles per digit slot, 2..65535
  parameter int GUARD         = 2,    // leading cycles of a slot with anodes off, < SCAN_DIV
  parameter int BLINK_FRAMES  = 64,   // frames per blink half-period, 1..1023
  parameter bit BLANK_LEADING = 1'b1  // blank the hours-tens digit when it is 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hrm,
  input  logic [3:0] hrl,
  input  logic [3:0] minm,
  input  logic [3:0] minl,
  input  logic [3:0] secm,
  input  logic [3:0] secl,
  input  logic       blink_en,
  input  logic [5:0] blink_mask,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err
);

  localparam logic [15:0] PCNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] GUARD_W   = 16'(GUARD);
  localparam logic [9:0]  FCNT_LAST = 10'(BLINK_FRAMES - 1);
  localparam logic [2:0]  IDX_LAST  = 3'd5;

  // Scan position and blink timebase.
  logic [15:0] pcnt;
  logic [2:0]  idx;
  logic [9:0]  fcnt;
  logic        phase;

  // Shadow copy of the time, refreshed only at frame boundaries so that a
  // frame never mixes digits from two different seconds.
  logic [3:0] sh_hrm;
  logic [3:0] sh_hrl;
  logic [3:0] sh_minm;
  logic [3:0] sh_minl;
  logic [3:0] sh_secm;
  logic [3:0] sh_secl;

  logic slot_end;
  logic frame_end;

  assign slot_end  = (pcnt == PCNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // BCD to segment pattern; non-decimal codes show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // True when the six digits do not form a legal 00:00:00..23:59:59 time.
  function automatic logic time_invalid(
    input logic [3:0] h_t, input logic [3:0] h_u,
    input logic [3:0] m_t, input logic [3:0] m_u,
    input logic [3:0] s_t, input logic [3:0] s_u
  );
    logic bad;
    bad = (h_t > 4'd9) || (h_u > 4'd9) || (m_t > 4'd9) ||
          (m_u > 4'd9) || (s_t > 4'd9) || (s_u > 4'd9);
    bad = bad || (s_t > 4'd5) || (m_t > 4'd5);
    bad = bad || (h_t > 4'd2);
    bad = bad || ((h_t == 4'd2) && (h_u > 4'd3));
    return bad;
  endfunction

  // Digit shown in the current slot, slot 0 being the rightmost (seconds units).
  logic [3:0] cur_digit;

  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      3'd0:    cur_digit = sh_secl;
      3'd1:    cur_digit = sh_secm;
      3'd2:    cur_digit = sh_minl;
      3'd3:    cur_digit = sh_minm;
      3'd4:    cur_digit = sh_hrl;
      3'd5:    cur_digit = sh_hrm;
      default: cur_digit = 4'd0;
    endcase
  end

  // Next-cycle display values.
  logic       in_guard;
  logic       lead_blank;
  logic       blink_off;
  logic [5:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign in_guard   = (pcnt < GUARD_W);
  assign lead_blank = BLANK_LEADING && (idx == IDX_LAST) && (cur_digit == 4'd0);
  assign blink_off  = blink_en && blink_mask[idx] && phase;

  always_comb begin
    an_nxt  = 6'b000000;
    seg_nxt = 7'h00;
    dp_nxt  = 1'b0;
    if (!in_guard) begin
      // Blinked-off and leading-zero digits keep their anode driven so the
      // scan duty cycle, and thus brightness of the others, stays constant.
      an_nxt = 6'b000001 << idx;
      dp_nxt = (idx == 3'd2) || (idx == 3'd4);
      if (!lead_blank && !blink_off) begin
        seg_nxt = seg_decode(cur_digit);
      end
    end
  end

  // Scan counters and blink timebase.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= 16'd0;
      idx   <= 3'd0;
      fcnt  <= 10'd0;
      phase <= 1'b0;
    end else begin
      if (slot_end) begin
        pcnt <= 16'd0;
        idx  <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
      if (frame_end) begin
        if (fcnt == FCNT_LAST) begin
          fcnt  <= 10'd0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 10'd1;
        end
      end
    end
  end

  // Snapshot and validity flag, both updated only at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_hrm  <= 4'd0;
      sh_hrl  <= 4'd0;
      sh_minm <= 4'd0;
      sh_minl <= 4'd0;
      sh_secm <= 4'd0;
      sh_secl <= 4'd0;
      err     <= 1'b0;
    end else if (frame_end) begin
      sh_hrm  <= hrm;
      sh_hrl  <= hrl;
      sh_minm <= minm;
      sh_minl <= minl;
      sh_secm <= secm;
      sh_secl <= secl;
      if (time_invalid(hrm, hrl, minm, minl, secm, secl)) begin
        err <= 1'b1;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 6'b000000;
      seg <= 7'h00;
      dp  <= 1'b0;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_seg_scan.sv
// Bench for rtc_seg_scan: two instances (leading-zero blanking on and off)
// share one set of inputs; a cycle-indexed model predicts every output.
module tb_rtc_seg_scan;

  localparam int SD = 4;        // cycles per slot
  localparam int GD = 1;        // guard cycles
  localparam int BF = 2;        // frames per blink half-period
  localparam int FR = 6 * SD;   // cycles per frame

  logic       clk;
  logic       rst;
  logic [3:0] hrm, hrl, minm, minl, secm, secl;
  logic       blink_en;
  logic [5:0] blink_mask;
  logic [5:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, err_a, err_b;

  rtc_seg_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst(rst), .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl),
    .secm(secm), .secl(secl), .blink_en(blink_en), .blink_mask(blink_mask),
    .an(an_a), .seg(seg_a), .dp(dp_a), .err(err_a)
  );

  rtc_seg_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rst(rst), .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl),
    .secm(secm), .secl(secl), .blink_en(blink_en), .blink_mask(blink_mask),
    .an(an_b), .seg(seg_b), .dp(dp_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] in_dig(input int i);
    case (i)
      0: return secl;  1: return secm;  2: return minl;
      3: return minm;  4: return hrl;   default: return hrm;
    endcase
  endfunction

  function automatic logic bad_time(input logic [3:0] d [6]);
    logic b;
    b = 1'b0;
    for (int j = 0; j < 6; j++) if (d[j] > 9) b = 1'b1;
    if (d[1] > 5 || d[3] > 5 || d[5] > 2) b = 1'b1;
    if (d[5] == 2 && d[4] > 3) b = 1'b1;
    return b;
  endfunction

  // Model: ms counts cycles since reset release; slot, position and blink
  // phase follow from it by division. Evaluated on the falling edge, where
  // the inputs the next rising edge will sample are already stable.
  int         ms;
  bit         primed = 1'b0;
  logic [3:0] snap [6];
  logic       m_err;
  logic [5:0] exp_an;
  logic [6:0] exp_seg_a, exp_seg_b, m_s;
  logic       exp_dp, exp_err, m_ph, m_blk;
  logic [3:0] m_d;
  logic [3:0] m_cap [6];
  int         m_p, m_i, m_k;

  initial begin
    forever begin
      @(negedge clk);
      if (primed) begin
        chk("an_a", 32'(an_a), 32'(exp_an));
        chk("seg_a", 32'(seg_a), 32'(exp_seg_a));
        chk("dp_a", 32'(dp_a), 32'(exp_dp));
        chk("err_a", 32'(err_a), 32'(exp_err));
        chk("an_b", 32'(an_b), 32'(exp_an));
        chk("seg_b", 32'(seg_b), 32'(exp_seg_b));
        chk("dp_b", 32'(dp_b), 32'(exp_dp));
        chk("err_b", 32'(err_b), 32'(exp_err));
      end
      if (rst) begin
        ms = 0;
        for (int j = 0; j < 6; j++) snap[j] = 4'd0;
        m_err = 1'b0;
        exp_an = '0; exp_seg_a = '0; exp_seg_b = '0; exp_dp = 1'b0; exp_err = 1'b0;
      end else begin
        m_p = ms % SD;
        m_i = (ms / SD) % 6;
        m_k = ms / FR;
        m_ph = ((m_k / BF) % 2) == 1;
        m_d = snap[m_i];
        if (m_p < GD) begin
          exp_an = '0; exp_seg_a = '0; exp_seg_b = '0; exp_dp = 1'b0;
        end else begin
          exp_an = 6'(1 << m_i);
          exp_dp = (m_i == 2) || (m_i == 4);
          m_s = seg_of(m_d);
          m_blk = blink_en && blink_mask[m_i] && m_ph;
          exp_seg_b = m_blk ? 7'h00 : m_s;
          exp_seg_a = (m_blk || (m_i == 5 && m_d == 0)) ? 7'h00 : m_s;
        end
        if (ms % FR == FR - 1) begin
          for (int j = 0; j < 6; j++) m_cap[j] = in_dig(j);
          for (int j = 0; j < 6; j++) snap[j] = m_cap[j];
          if (bad_time(m_cap)) m_err = 1'b1;
        end
        exp_err = m_err;
        ms++;
      end
      primed = 1'b1;
    end
  end

  // Output index (cycles since release) at which state (frame k, slot i, pos p) is visible.
  function automatic int st(input int k, input int i, input int p);
    return k * FR + i * SD + p + 1;
  endfunction

  task automatic wait_ms(input int target);
    int n;
    n = 0;
    while (ms != target && n < 5000) begin
      @(posedge clk); #2;
      n++;
    end
    if (ms != target) chk("wait_timeout", 32'(ms), 32'(target));
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    hrm = a; hrl = b; minm = c; minl = d; secm = e; secl = f;
  endtask

  function automatic logic [3:0] rnd_dig(input int maxv);
    if ($urandom_range(0, 15) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, maxv));
  endfunction

  initial begin
    rst = 1'b1;
    blink_en = 1'b0;
    blink_mask = 6'b000000;
    set_time(1, 2, 3, 4, 5, 6);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_an", 32'(an_a), 32'h0);
    chk("rst_seg", 32'(seg_a), 32'h0);
    chk("rst_dp", 32'(dp_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    rst = 1'b0;

    // First frame: shadows still zero.
    wait_ms(st(0, 0, 2)); chk("f0_s0_seg", 32'(seg_a), 32'h3F); chk("f0_s0_an", 32'(an_a), 32'h01);
    wait_ms(st(0, 5, 2)); chk("f0_s5_seg", 32'(seg_a), 32'h00); chk("f0_s5_an", 32'(an_a), 32'h20);
    chk("f0_s5_seg_nolz", 32'(seg_b), 32'h3F);
    // Second frame shows 12:34:56.
    wait_ms(st(1, 0, 0)); chk("guard_an", 32'(an_a), 32'h0); chk("guard_seg", 32'(seg_a), 32'h0);
    wait_ms(st(1, 0, 1)); chk("s0_seg", 32'(seg_a), 32'h7D); chk("s0_an", 32'(an_a), 32'h01);
    wait_ms(st(1, 1, 1)); chk("s1_seg", 32'(seg_a), 32'h6D);
    wait_ms(st(1, 2, 1)); chk("s2_seg", 32'(seg_a), 32'h66); chk("s2_dp", 32'(dp_a), 32'h1);
    // Tearing: inputs change mid-frame.
    wait_ms(st(1, 3, 0)); set_time(2, 3, 5, 9, 5, 9);
    wait_ms(st(1, 3, 1)); chk("s3_seg_old", 32'(seg_a), 32'h4F); chk("s3_dp", 32'(dp_a), 32'h0);
    wait_ms(st(1, 4, 1)); chk("s4_seg_old", 32'(seg_a), 32'h5B); chk("s4_dp", 32'(dp_a), 32'h1);
    wait_ms(st(1, 5, 1)); chk("s5_seg_old", 32'(seg_a), 32'h06);
    wait_ms(st(2, 0, 0)); hrl = 4'hA;
    wait_ms(st(2, 0, 1)); chk("new_s0_seg", 32'(seg_a), 32'h6F);
    wait_ms(st(2, 5, 1)); chk("new_s5_seg", 32'(seg_a), 32'h5B);
    wait_ms(st(2, 5, 2)); chk("err_before", 32'(err_a), 32'h0);
    wait_ms(st(3, 0, 0)); chk("err_hex", 32'(err_a), 32'h1);
    wait_ms(st(3, 4, 1)); chk("hex_seg", 32'(seg_a), 32'h00); chk("hex_an", 32'(an_a), 32'h10);
    wait_ms(st(3, 5, 0)); set_time(1, 2, 3, 4, 5, 6);
    wait_ms(st(4, 0, 0)); blink_en = 1'b1; blink_mask = 6'b000011;
    wait_ms(st(4, 5, 1)); chk("restore_seg", 32'(seg_a), 32'h06); chk("err_sticky", 32'(err_a), 32'h1);
    wait_ms(st(5, 0, 1)); chk("blink_on_seg", 32'(seg_a), 32'h7D);
    wait_ms(st(6, 0, 1)); chk("blink_off_s0", 32'(seg_a), 32'h00); chk("blink_off_an", 32'(an_a), 32'h01);
    wait_ms(st(6, 1, 2)); chk("blink_off_s1", 32'(seg_a), 32'h00); chk("blink_off_an1", 32'(an_a), 32'h02);
    wait_ms(st(6, 2, 1)); chk("blink_other", 32'(seg_a), 32'h66);
    wait_ms(st(8, 0, 1)); chk("blink_back", 32'(seg_a), 32'h7D);
    // Reset mid-frame at slot 3, position 2.
    wait_ms(8 * FR + 3 * SD + 2);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_an", 32'(an_a), 32'h0); chk("mid_rst_seg", 32'(seg_a), 32'h0);
    chk("mid_rst_dp", 32'(dp_a), 32'h0); chk("mid_rst_err", 32'(err_a), 32'h0);
    rst = 1'b0;
    blink_en = 1'b0; blink_mask = 6'b000000;
    set_time(2, 4, 0, 0, 0, 0);
    wait_ms(FR - 1); chk("snap_not_yet", 32'(err_a), 32'h0);
    wait_ms(FR);     chk("err_24h", 32'(err_a), 32'h1);
    wait_ms(st(1, 0, 0)); set_time(0, 7, 1, 5, 3, 0);
    wait_ms(st(1, 4, 1)); chk("h24_hrl", 32'(seg_a), 32'h66);
    wait_ms(st(1, 5, 1)); chk("h24_hrm", 32'(seg_a), 32'h5B);
    wait_ms(st(2, 4, 1)); chk("lz_hrl", 32'(seg_a), 32'h07);
    wait_ms(st(2, 5, 1)); chk("lz_seg", 32'(seg_a), 32'h00); chk("lz_an", 32'(an_a), 32'h20);
    chk("nolz_seg", 32'(seg_b), 32'h3F);

    // Randomised traffic; the model checks every cycle.
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0)
        set_time(rnd_dig(2), rnd_dig(9), rnd_dig(5), rnd_dig(9), rnd_dig(5), rnd_dig(9));
      if ($urandom_range(0, 29) == 0) begin
        blink_en = 1'($urandom_range(0, 1));
        blink_mask = 6'($urandom_range(0, 63));
      end
    end
    rst = 1'b0;
    @(posedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
